// File: rtl/reset_pkg.sv
// Shared types and helpers for the reset request sequencer.
package reset_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ASSERT = 2'd1,
      SETTLE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE = 2'b00,
      CAUSE_SW   = 2'b01,
      CAUSE_BTN  = 2'b10,
      CAUSE_WDOG = 2'b11
   } cause_t;

   localparam int unsigned CNT_W = 8;

   function automatic int unsigned cnt_width(input int unsigned v);
      return $clog2(v) + 1;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button path: two-flop synchronizer, debounce filter, rising-edge request pulse.
module btn_debounce
   import reset_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic CLK,
   input  logic RST,
   input  logic BTN_RAW,
   output logic btn_req
);

   localparam int unsigned        DB_W    = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [DB_W-1:0]    DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic            sync1;
   logic            sync2;
   logic            stable;
   logic [DB_W-1:0] db_cnt;

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         stable  <= 1'b0;
         db_cnt  <= '0;
         btn_req <= 1'b0;
      end else begin
         sync1   <= BTN_RAW;
         sync2   <= sync1;
         btn_req <= 1'b0;
         if (sync2 == stable) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            // This increment would reach DEBOUNCE_CYCLES: accept the level instead.
            stable  <= sync2;
            db_cnt  <= '0;
            btn_req <= sync2;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/reset_request_sequencer.sv
// Merges software, push-button and watchdog reset sources into one held,
// lockout-protected assertion request with cause and completion count.
module reset_request_sequencer
   import reset_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES     = 16,
   parameter int unsigned SETTLE_CYCLES   = 8,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned WDOG_LIMIT      = 1000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       REQ_SW,
   input  logic       BTN_RAW,
   input  logic       WDOG_EN,
   input  logic       WDOG_KICK,
   output logic       ASSERT_OUT,
   output logic       BUSY,
   output logic [1:0] CAUSE,
   output logic [7:0] RESET_CNT
);

   localparam int unsigned       HOLD_W      = cnt_width(HOLD_CYCLES);
   localparam int unsigned       SETTLE_W    = cnt_width(SETTLE_CYCLES);
   localparam int unsigned       WD_W        = cnt_width(WDOG_LIMIT);
   localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
   localparam logic [WD_W-1:0]     WD_LAST     = WD_W'(WDOG_LIMIT - 1);

   state_t              state_q, state_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [SETTLE_W-1:0] settle_q, settle_d;
   cause_t              cause_q, cause_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                assert_q;
   logic                busy_q;
   logic [WD_W-1:0]     wd_cnt;
   logic                wd_req;
   logic                btn_req;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn_debounce (
      .CLK     (CLK),
      .RST     (RST),
      .BTN_RAW (BTN_RAW),
      .btn_req (btn_req)
   );

   // Watchdog only runs while idle, so a lockout never leaves a stale count behind.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wd_cnt <= '0;
         wd_req <= 1'b0;
      end else begin
         wd_req <= 1'b0;
         if (!WDOG_EN || (state_q != IDLE) || WDOG_KICK) begin
            wd_cnt <= '0;
         end else if (wd_cnt == WD_LAST) begin
            wd_cnt <= '0;
            wd_req <= 1'b1;
         end else begin
            wd_cnt <= wd_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      settle_d = settle_q;
      cause_d  = cause_q;
      cnt_d    = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (REQ_SW || btn_req || wd_req) begin
               state_d = ASSERT;
               hold_d  = '0;
               if (REQ_SW)       cause_d = CAUSE_SW;
               else if (btn_req) cause_d = CAUSE_BTN;
               else              cause_d = CAUSE_WDOG;
            end
         end
         ASSERT: begin
            if (hold_q == HOLD_LAST) begin
               state_d  = SETTLE;
               settle_d = '0;
               cnt_d    = sat_inc(cnt_q);
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         SETTLE: begin
            if (settle_q == SETTLE_LAST) state_d = IDLE;
            else                         settle_d = settle_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they change with the state register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= IDLE;
         hold_q   <= '0;
         settle_q <= '0;
         cause_q  <= CAUSE_NONE;
         cnt_q    <= '0;
         assert_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         settle_q <= settle_d;
         cause_q  <= cause_d;
         cnt_q    <= cnt_d;
         assert_q <= (state_d == ASSERT);
         busy_q   <= (state_d != IDLE);
      end
   end

   assign ASSERT_OUT = assert_q;
   assign BUSY       = busy_q;
   assign CAUSE      = cause_q;
   assign RESET_CNT  = cnt_q;

endmodule

// File: tb/tb_reset_request_sequencer.sv
// Directed bench for reset_request_sequencer with an assertion-pulse scoreboard.
module tb_reset_request_sequencer;

   logic       CLK;
   logic       RST;
   logic       REQ_SW;
   logic       BTN_RAW;
   logic       WDOG_EN;
   logic       WDOG_KICK;
   logic       ASSERT_OUT;
   logic       BUSY;
   logic [1:0] CAUSE;
   logic [7:0] RESET_CNT;

   reset_request_sequencer #(
      .HOLD_CYCLES     (16),
      .SETTLE_CYCLES   (8),
      .DEBOUNCE_CYCLES (4),
      .WDOG_LIMIT      (1000)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .REQ_SW     (REQ_SW),
      .BTN_RAW    (BTN_RAW),
      .WDOG_EN    (WDOG_EN),
      .WDOG_KICK  (WDOG_KICK),
      .ASSERT_OUT (ASSERT_OUT),
      .BUSY       (BUSY),
      .CAUSE      (CAUSE),
      .RESET_CNT  (RESET_CNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [1:0] cause;
      logic [7:0] cnt_before;
      logic [7:0] cnt_after;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fails  = 0;
   int   exp_cnt  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [1:0] cause);
      exp_t e;
      e.cause      = cause;
      e.cnt_before = 8'(exp_cnt);
      exp_cnt      = (exp_cnt == 255) ? 255 : exp_cnt + 1;
      e.cnt_after  = 8'(exp_cnt);
      sb.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic wait_rise(input int budget, output int n);
      n = 0;
      while (!ASSERT_OUT && n < budget) begin
         @(posedge CLK);
         #1;
         n++;
      end
   endtask

   // Monitor: every assertion pulse must match the head of the scoreboard.
   logic prev_assert = 1'b0;
   logic active      = 1'b0;
   logic rst_seen    = 1'b0;
   int   width       = 0;
   exp_t cur;

   always @(negedge CLK) begin
      if (RST) rst_seen = 1'b1;
      if (ASSERT_OUT && !prev_assert) begin
         check("sb_nonempty", 32'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            cur = sb.pop_front();
            check("rise_cause", 32'(CAUSE), 32'(cur.cause));
            check("rise_cnt", 32'(RESET_CNT), 32'(cur.cnt_before));
         end
         width    = 1;
         rst_seen = 1'b0;
         active   = 1'b1;
      end else if (ASSERT_OUT) begin
         width++;
      end else if (prev_assert && active) begin
         if (!rst_seen) begin
            check("pulse_width", 32'(width), 16);
            check("fall_cnt", 32'(RESET_CNT), 32'(cur.cnt_after));
         end
         active = 1'b0;
      end
      prev_assert = ASSERT_OUT;
   end

   int n;

   initial begin
      RST = 1'b1; REQ_SW = 1'b0; BTN_RAW = 1'b0; WDOG_EN = 1'b0; WDOG_KICK = 1'b0;
      tick(3);
      check("rst_assert", 32'(ASSERT_OUT), 0);
      check("rst_busy", 32'(BUSY), 0);
      check("rst_cause", 32'(CAUSE), 0);
      check("rst_cnt", 32'(RESET_CNT), 0);
      RST = 1'b0;
      tick(6);

      // Software request: 16 cycles asserted, 24 cycles busy.
      REQ_SW = 1'b1; push_exp(2'b01);
      tick(1);
      REQ_SW = 1'b0;
      check("sw_assert_first", 32'(ASSERT_OUT), 1);
      check("sw_busy_first", 32'(BUSY), 1);
      tick(15);
      check("sw_assert_last", 32'(ASSERT_OUT), 1);
      tick(1);
      check("sw_assert_end", 32'(ASSERT_OUT), 0);
      check("sw_busy_settle", 32'(BUSY), 1);
      tick(7);
      check("sw_busy_last", 32'(BUSY), 1);
      tick(1);
      check("sw_busy_end", 32'(BUSY), 0);
      check("sw_cause", 32'(CAUSE), 1);
      check("sw_cnt", 32'(RESET_CNT), 1);

      // Lockout: requests during ASSERT and last SETTLE cycle dropped.
      REQ_SW = 1'b1; push_exp(2'b01);
      tick(1);
      REQ_SW = 1'b0;
      tick(3);
      REQ_SW = 1'b1;
      tick(1);
      REQ_SW = 1'b0;
      tick(19);
      check("lock_busy_last", 32'(BUSY), 1);
      REQ_SW = 1'b1;
      tick(1);
      REQ_SW = 1'b0;
      check("lock_drop_busy", 32'(BUSY), 0);
      check("lock_drop_assert", 32'(ASSERT_OUT), 0);
      REQ_SW = 1'b1; push_exp(2'b01);
      tick(1);
      REQ_SW = 1'b0;
      check("lock_accept", 32'(ASSERT_OUT), 1);
      tick(30);
      check("lock_cnt", 32'(RESET_CNT), 3);

      // Button: 3-cycle glitch ignored, held level gives one request.
      BTN_RAW = 1'b1;
      tick(3);
      BTN_RAW = 1'b0;
      tick(20);
      check("glitch_busy", 32'(BUSY), 0);
      BTN_RAW = 1'b1; push_exp(2'b10);
      wait_rise(50, n);
      check("btn_latency", 32'(n), 7);
      check("btn_cause", 32'(CAUSE), 2);
      tick(13);
      BTN_RAW = 1'b0;
      tick(40);
      check("btn_idle", 32'(BUSY), 0);

      // Watchdog without kicks.
      WDOG_EN = 1'b1; push_exp(2'b11);
      wait_rise(1100, n);
      check("wd_latency", 32'(n), 1001);
      check("wd_cause", 32'(CAUSE), 3);
      WDOG_EN = 1'b0;
      tick(30);

      // Watchdog kicked every 500 cycles never fires.
      WDOG_EN = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(499);
         WDOG_KICK = 1'b1;
         tick(1);
         WDOG_KICK = 1'b0;
      end
      check("kick_busy", 32'(BUSY), 0);
      check("kick_cnt", 32'(RESET_CNT), 5);
      WDOG_EN = 1'b0;
      tick(2);

      // Priority: sw, btn and watchdog requests land in the same cycle.
      WDOG_EN = 1'b1;
      tick(994);
      BTN_RAW = 1'b1;
      tick(6);
      check("prio_pre_busy", 32'(BUSY), 0);
      REQ_SW = 1'b1; push_exp(2'b01);
      tick(1);
      REQ_SW = 1'b0;
      WDOG_EN = 1'b0;
      check("prio_assert", 32'(ASSERT_OUT), 1);
      check("prio_cause", 32'(CAUSE), 1);
      tick(40);
      BTN_RAW = 1'b0;
      tick(20);
      check("prio_cnt", 32'(RESET_CNT), 6);

      // Abort at hold cycle 5.
      REQ_SW = 1'b1; push_exp(2'b01);
      tick(1);
      REQ_SW = 1'b0;
      tick(4);
      check("abort_pre", 32'(ASSERT_OUT), 1);
      RST = 1'b1;
      tick(1);
      RST = 1'b0;
      exp_cnt = 0;
      check("abort_assert", 32'(ASSERT_OUT), 0);
      check("abort_busy", 32'(BUSY), 0);
      check("abort_cnt", 32'(RESET_CNT), 0);
      check("abort_cause", 32'(CAUSE), 0);
      tick(3);

      // Saturation after 260 back-to-back requests.
      for (int i = 0; i < 260; i++) begin
         REQ_SW = 1'b1; push_exp(2'b01);
         tick(1);
         REQ_SW = 1'b0;
         tick(24);
      end
      tick(2);
      check("sat_cnt", 32'(RESET_CNT), 255);
      check("sb_drained", 32'(sb.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/reset_request_sequencer.md
Name: reset_request_sequencer

Overview:
- Upstream stage of the MakeReset/SyncReset reset-generation path.
- Merges three reset sources into one clean, fixed-width assertion request for the downstream ASSERT_IN input: a software pulse, a raw push-button, and a watchdog timeout.
- Enforces a minimum hold time, a settle/lockout window and a source priority.
- Reports busy status, the cause of the last reset and a count of completed resets.

Parameters:
- HOLD_CYCLES, 16: cycles ASSERT_OUT stays high per request; must be >= 1.
- SETTLE_CYCLES, 8: lockout cycles after deassertion; must be >= 1.
- DEBOUNCE_CYCLES, 4: consecutive stable cycles needed to accept a button level change; must be >= 1.
- WDOG_LIMIT, 1000: idle cycles without a kick before a watchdog request fires; must be >= 2.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- REQ_SW  in  1  software reset request, single-cycle pulse, CLK domain
- BTN_RAW  in  1  raw asynchronous push-button, active-high
- WDOG_EN  in  1  watchdog enable
- WDOG_KICK  in  1  watchdog service pulse
- ASSERT_OUT  out  1  reset assertion request, drives downstream ASSERT_IN
- BUSY  out  1  high while asserting or settling
- CAUSE  out  2  cause of last reset: 00 none, 01 sw, 10 btn, 11 wdog
- RESET_CNT  out  8  completed resets, saturating

Behaviour:
- Clocking and reset: already decided, reset RST is synchronous, active-high; clock is CLK. All state is registered on posedge CLK.
- Values on RST:
  - state = IDLE; ASSERT_OUT = 0; BUSY = 0; CAUSE = 00; RESET_CNT = 0.
  - Button synchronizer, stable level and debounce counter = 0.
  - Watchdog counter = 0.
- RST mid-operation aborts ASSERT or SETTLE. ASSERT_OUT is 0 in the cycle after RST is sampled.
- Button path:
  - Two-flop synchronizer on BTN_RAW.
  - Debounce counter increments while the synchronized level differs from the stable level, and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES, the stable level takes the new value and the counter clears.
  - A 0->1 transition of the stable level produces a one-cycle btn_req.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Watchdog:
  - In IDLE with WDOG_EN = 1, the counter increments each cycle.
  - WDOG_KICK clears the counter and has priority over the increment.
  - When the counter equals WDOG_LIMIT-1, wd_req fires for one cycle and the counter clears.
  - The counter is held at 0 when WDOG_EN = 0 or state != IDLE.
- FSM states: IDLE, ASSERT, SETTLE.
  - IDLE: if any request is sampled in cycle N, go to ASSERT. Priority is sw > btn > wdog. CAUSE is latched from the winning source at the same edge.
  - ASSERT: ASSERT_OUT is registered high for exactly HOLD_CYCLES cycles, N+1 through N+HOLD_CYCLES. The hold counter runs from 0 to HOLD_CYCLES-1, then the FSM goes to SETTLE and RESET_CNT increments, saturating at 255.
  - SETTLE: ASSERT_OUT = 0 for exactly SETTLE_CYCLES cycles, then IDLE.
- BUSY = 1 in ASSERT and SETTLE; it rises and falls with the state register.
- Requests arriving in ASSERT or SETTLE are dropped, not queued. This covers REQ_SW, btn_req edges and kicks. The debounce filter keeps tracking, so a button held through the lockout does not retrigger.
- Simultaneous requests: only one reset occurs and CAUSE reports the highest-priority source.
- REQ_SW in the same cycle the FSM returns SETTLE->IDLE is dropped, because the state is still SETTLE in that cycle.
- Counter widths use $clog2 of each parameter plus 1; there is no wrap inside a phase.

Decomposition:
- Shared package reset_pkg:
  - state enum: IDLE = 2'd0, ASSERT = 2'd1, SETTLE = 2'd2.
  - CAUSE codes: CAUSE_NONE, CAUSE_SW, CAUSE_BTN, CAUSE_WDOG.
- One sub-module, btn_debounce (synchronizer, debounce counter, rising-edge pulse), parameterised by DEBOUNCE_CYCLES.
- The FSM and watchdog stay in the top module.

Test Plan:
- Reset and software request: RST high 3 cycles, then REQ_SW pulse at cycle 10 -> ASSERT_OUT high in cycles 11-26 (16 cycles); BUSY high in cycles 11-34; CAUSE = 01; RESET_CNT = 1.
- Button debounce: BTN_RAW glitch of 3 cycles -> no assertion. BTN_RAW held high 20 cycles -> exactly one assertion, first high 2 (sync) + 4 (debounce) + 1 cycles after the rise; CAUSE = 10.
- Watchdog: WDOG_EN = 1, no kicks -> ASSERT_OUT rises 1001 cycles after enable; CAUSE = 11. Kick every 500 cycles -> no assertion over 5000 cycles.
- Priority: REQ_SW, btn_req and wd_req forced in the same cycle -> one 16-cycle assertion; CAUSE = 01; RESET_CNT increments by 1.
- Lockout: REQ_SW during ASSERT and again during the last SETTLE cycle -> both dropped; a REQ_SW one cycle after BUSY falls is accepted.
- Abort and saturation: RST asserted at hold cycle 5 -> ASSERT_OUT = 0 and BUSY = 0 on the next cycle; RESET_CNT = 0. Then 260 back-to-back requests -> RESET_CNT saturates at 255.
